// File: rtl/button_direction_conditioner_pkg.sv
// Shared constants for the button direction conditioner.
// Debounce defaults and the Mode input encodings.
package button_direction_conditioner_pkg;

    localparam int DB_CYCLES_DEF = 4;
    localparam int CNT_W_DEF     = 8;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    typedef struct packed {
        logic up;
        logic down;
    } dir_t;

endpackage

// File: rtl/button_direction_conditioner_if.sv
// Button, mode and direction-request signals of the conditioner.
// master drives buttons/mode, slave is the conditioner itself.
interface button_direction_conditioner_if;

    logic BtnUp;
    logic BtnDown;
    logic Mode;
    logic Up;
    logic Down;

    modport master (
        output BtnUp,
        output BtnDown,
        output Mode,
        input  Up,
        input  Down
    );

    modport slave (
        input  BtnUp,
        input  BtnDown,
        input  Mode,
        output Up,
        output Down
    );

endinterface

// File: rtl/button_direction_conditioner_debounce_channel.sv
// One button channel: two-flop synchronizer, debounce counter
// and the debounced level it maintains.
module debounce_channel #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Counter clears on any match and on the toggle, so it never wraps.
    always_comb begin
        sync_d  = {sync_q[0], raw};
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_direction_conditioner.sv
// Debounces up/down buttons and turns them into registered,
// mutually exclusive Up/Down requests in pulse or level mode.
module button_direction_conditioner
    import button_direction_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic                           Clk,
    input logic                           South,
    button_direction_conditioner_if.slave io
);

    logic up_lvl;
    logic down_lvl;

    debounce_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_up_ch (
        .clk   (Clk),
        .rst   (South),
        .raw   (io.BtnUp),
        .level (up_lvl)
    );

    debounce_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_down_ch (
        .clk   (Clk),
        .rst   (South),
        .raw   (io.BtnDown),
        .level (down_lvl)
    );

    dir_t lvl;
    dir_t req;
    dir_t prev_q;
    dir_t prev_d;
    dir_t out_q;
    dir_t out_d;

    // History always tracks the level, so a suppressed edge is lost.
    always_comb begin
        lvl.up   = up_lvl;
        lvl.down = down_lvl;
        prev_d   = lvl;
        req      = '0;
        out_d    = '0;
        unique case (io.Mode)
            MODE_LEVEL: req = lvl;
            default:    req = lvl & ~prev_q;
        endcase
        if (!(req.up && req.down)) begin
            out_d = req;
        end
    end

    always_ff @(posedge Clk) begin
        if (South) begin
            prev_q <= '0;
            out_q  <= '0;
        end else begin
            prev_q <= prev_d;
            out_q  <= out_d;
        end
    end

    assign io.Up   = out_q.up;
    assign io.Down = out_q.down;

endmodule

// File: tb/tb_button_direction_conditioner.sv
// Bench for button_direction_conditioner: directed scenarios plus
// random button traffic checked against a window-based model.
module tb_button_direction_conditioner;

    import button_direction_conditioner_pkg::*;

    localparam int DB = DB_CYCLES_DEF;

    logic clk = 1'b0;
    logic south;

    always #5 clk = ~clk;

    button_direction_conditioner_if bus ();

    button_direction_conditioner #(
        .DB_CYCLES (DB),
        .CNT_W     (CNT_W_DEF)
    ) dut (
        .Clk   (clk),
        .South (south),
        .io    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(string tag, logic [31:0] obs,
                            logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Model: raw delayed two edges, then a level flips once the last
    // DB synchronized samples since the previous flip all differ.
    bit m_d1 [2];
    bit m_d2 [2];
    bit m_lvl [2];
    bit m_prev [2];
    bit m_out [2];
    bit m_win [2][DB];
    int m_wn [2];

    task automatic model_step(bit rst, bit bu, bit bd, bit md);
        bit req [2];
        bit nlvl [2];
        bit raw [2];
        bit all_diff;
        raw[0] = bu;
        raw[1] = bd;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0;
                m_prev[c] = 0; m_out[c] = 0; m_wn[c] = 0;
            end
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (md == MODE_LEVEL) req[c] = m_lvl[c];
            else req[c] = m_lvl[c] && !m_prev[c];
            for (int k = DB - 1; k > 0; k--)
                m_win[c][k] = m_win[c][k-1];
            m_win[c][0] = m_d2[c];
            if (m_wn[c] < DB) m_wn[c]++;
            all_diff = (m_wn[c] == DB);
            for (int k = 0; k < DB; k++)
                if (m_win[c][k] == m_lvl[c]) all_diff = 0;
            nlvl[c] = all_diff ? !m_lvl[c] : m_lvl[c];
            if (all_diff) m_wn[c] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            m_out[c] = (req[0] && req[1]) ? 1'b0 : req[c];
            m_prev[c] = m_lvl[c];
            m_lvl[c]  = nlvl[c];
            m_d2[c]   = m_d1[c];
            m_d1[c]   = raw[c];
        end
    endtask

    int ups, downs, first_up, first_down, idx;

    task automatic tick(bit rst, bit bu, bit bd, bit md);
        south       = rst;
        bus.BtnUp   = bu;
        bus.BtnDown = bd;
        bus.Mode    = md;
        @(posedge clk);
        model_step(rst, bu, bd, md);
        #1;
        check_eq("up", bus.Up, m_out[0]);
        check_eq("down", bus.Down, m_out[1]);
        check_eq("excl", bus.Up & bus.Down, 0);
        if (bus.Up === 1'b1) begin
            if (first_up < 0) first_up = idx;
            ups++;
        end
        if (bus.Down === 1'b1) begin
            if (first_down < 0) first_down = idx;
            downs++;
        end
        idx++;
    endtask

    task automatic clr_stats();
        ups = 0; downs = 0; idx = 0;
        first_up = -1; first_down = -1;
    endtask

    task automatic run(int n, bit rst, bit bu, bit bd, bit md);
        for (int i = 0; i < n; i++) tick(rst, bu, bd, md);
    endtask

    initial begin
        bit bu, bd, md, rs;
        int hold;
        south = 1'b1;
        bus.BtnUp = 0; bus.BtnDown = 0; bus.Mode = MODE_PULSE;

        // Reset with BtnUp held, then release reset.
        clr_stats();
        run(2, 1, 1, 0, MODE_PULSE);
        check_eq("rst_quiet", ups + downs, 0);
        clr_stats();
        run(12, 0, 1, 0, MODE_PULSE);
        check_eq("rst_pulses", ups, 1);
        check_eq("rst_edge", first_up, DB + 2);
        run(12, 0, 0, 0, MODE_PULSE);

        // Clean press, pulse mode, held 200 ns.
        clr_stats();
        run(20, 0, 1, 0, MODE_PULSE);
        run(10, 0, 0, 0, MODE_PULSE);
        check_eq("press_pulses", ups, 1);
        check_eq("press_edge", first_up, DB + 2);
        check_eq("press_down", downs, 0);

        // Bounce on BtnDown, then held.
        clr_stats();
        run(1, 0, 0, 1, MODE_PULSE);
        run(1, 0, 0, 0, MODE_PULSE);
        run(1, 0, 0, 1, MODE_PULSE);
        run(1, 0, 0, 0, MODE_PULSE);
        run(16, 0, 0, 1, MODE_PULSE);
        run(10, 0, 0, 0, MODE_PULSE);
        check_eq("bounce_pulses", downs, 1);
        check_eq("bounce_edge", first_down, 4 + DB + 2);

        // Short glitch on BtnUp.
        clr_stats();
        run(2, 0, 1, 0, MODE_PULSE);
        run(12, 0, 0, 0, MODE_PULSE);
        check_eq("glitch", ups, 0);

        // Simultaneous press, pulse then level mode.
        clr_stats();
        run(15, 0, 1, 1, MODE_PULSE);
        check_eq("conf_pulse", ups + downs, 0);
        run(15, 0, 1, 1, MODE_LEVEL);
        check_eq("conf_level", ups + downs, 0);
        run(12, 0, 0, 0, MODE_PULSE);

        // Level mode hold: high for as many cycles as it was held.
        clr_stats();
        run(30, 0, 1, 0, MODE_LEVEL);
        run(12, 0, 0, 0, MODE_LEVEL);
        check_eq("level_cycles", ups, 30);
        check_eq("level_first", first_up, DB + 2);
        check_eq("level_wrap20", ups % 20, 10);

        // Random traffic, mode flips and occasional resets.
        bu = 0; bd = 0; md = MODE_PULSE;
        for (int seg = 0; seg < 600; seg++) begin
            hold = $urandom_range(1, 12);
            if ($urandom_range(0, 2) == 0) bu = !bu;
            if ($urandom_range(0, 2) == 0) bd = !bd;
            if ($urandom_range(0, 9) == 0) md = !md;
            rs = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < hold; i++) begin
                tick(rs && i == 0, bu, bd, md);
                if ($urandom_range(0, 30) == 0) md = !md;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
